// File: rtl/servo_bank.sv
// Multi-channel hobby-servo PWM bank: one shared frame counter, per-channel
// target/current pulse widths. Optional slew limiting under SERVO_BANK_SLEW_EN.
module servo_bank #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int PERIOD   = 500_000,
  parameter int CHANNELS = 4,
  parameter int STEP     = 250,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [7:0]          wr_pos,
  output logic [CHANNELS-1:0] servo_out,
  output logic [CHANNELS-1:0] busy,
  output logic                frame_tick
);

  localparam int DUTY_MIN = PERIOD / 20;
  localparam int DUTY_MAX = PERIOD / 10;
  localparam int SPAN     = DUTY_MAX - DUTY_MIN;

  if (CHANNELS < 1 || CHANNELS > 16 || STEP < 1 || CLK_FREQ < 1) begin : g_param_err
    $error("servo_bank: parameter out of range");
  end

  logic [31:0] counter_reg;
  logic        frame_end;
  logic        wr_hit;
  logic [31:0] map_full;
  logic [31:0] wr_target;

  assign frame_end = (counter_reg == 32'(PERIOD - 1));
  // Gated by rst_n so the tick stays low during reset yet fires on the first
  // counter==0 cycle after release.
  assign frame_tick = rst_n & (counter_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg <= '0;
    end else if (frame_end) begin
      counter_reg <= '0;
    end else begin
      counter_reg <= counter_reg + 32'd1;
    end
  end

  assign wr_hit   = wr_en && (32'(wr_ch) < 32'(CHANNELS));
  assign map_full = 32'(wr_pos) * 32'(SPAN);
  // The >>8 scaling tops out one LSB short, so full scale is pinned explicitly.
  assign wr_target = (wr_pos == 8'hFF) ? 32'(DUTY_MAX)
                                       : 32'(DUTY_MIN) + (map_full >> 8);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [31:0] target_reg;
    logic [31:0] cur_reg;
    logic [31:0] cur_next;
    logic        pwm_reg;

    always_comb begin
      cur_next = target_reg;
`ifdef SERVO_BANK_SLEW_EN
      if (cur_reg < target_reg) begin
        cur_next = ((target_reg - cur_reg) > 32'(STEP)) ? cur_reg + 32'(STEP) : target_reg;
      end else if (cur_reg > target_reg) begin
        cur_next = ((cur_reg - target_reg) > 32'(STEP)) ? cur_reg - 32'(STEP) : target_reg;
      end
`else
      cur_next = target_reg;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        target_reg <= 32'(DUTY_MIN);
        cur_reg    <= 32'(DUTY_MIN);
        pwm_reg    <= 1'b0;
      end else begin
        if (wr_hit && (wr_ch == CW'(gi))) begin
          target_reg <= wr_target;
        end
        // Width changes only across the frame boundary; uses the pre-write target.
        if (frame_end) begin
          cur_reg <= cur_next;
        end
        pwm_reg <= (counter_reg < cur_reg);
      end
    end

    assign servo_out[gi] = pwm_reg;
    assign busy[gi]      = (cur_reg != target_reg);
  end

endmodule

// File: doc/servo_bank.md
SERVO_BANK -- requirements
Module: servo_bank

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, clock frequency in Hz.
REQ-002 Parameter PERIOD, default 500_000, frame length in clk cycles (50 Hz at default clock).
REQ-003 Parameter CHANNELS, default 4, number of independent servo outputs, range 1..16.
REQ-004 Parameter STEP, default 250, maximum pulse-width change per frame in cycles, at least 1.
REQ-005 Derived constants: DUTY_MIN = PERIOD/20 (1 ms); DUTY_MAX = PERIOD/10 (2 ms); SPAN = DUTY_MAX-DUTY_MIN; CW = max(1,$clog2(CHANNELS)).
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  single-cycle position write strobe.
REQ-009 wr_ch  input  CW  channel index for the write.
REQ-010 wr_pos  input  8  target position, 0 = DUTY_MIN, 255 = DUTY_MAX.
REQ-011 servo_out  output  CHANNELS  registered PWM output per channel.
REQ-012 busy  output  CHANNELS  high while the channel's current width differs from its target.
REQ-013 frame_tick  output  1  one-cycle pulse marking the start of each frame.

Function
REQ-014 A shared 32-bit frame counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-015 frame_tick SHALL be high for exactly the one cycle in which the counter equals 0.
REQ-016 servo_out[i] SHALL be registered as (counter < cur[i]), one cycle behind the counter, so each frame carries exactly cur[i] high cycles.
REQ-017 Position mapping: target = DUTY_MIN + ((wr_pos*SPAN) >> 8), computed in 32 bits; wr_pos = 255 SHALL map to DUTY_MAX exactly.
REQ-018 On wr_en with wr_ch < CHANNELS, target[wr_ch] SHALL update on that clock edge; wr_ch >= CHANNELS SHALL be ignored with no state change.
REQ-019 cur[i] SHALL change only on the edge where the counter leaves PERIOD-1, so a pulse is never truncated or extended mid-frame.
REQ-020 A write on the same edge as the frame update SHALL store the new target, while that update uses the previous target.
REQ-021 Multiple writes to one channel within a frame: the last write wins.
REQ-022 busy[i] SHALL equal (cur[i] != target[i]), driven from registers.

Reset
REQ-023 While rst_n is low: counter = 0, target[i] = cur[i] = DUTY_MIN, servo_out = 0, busy = 0, frame_tick = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no residual pulse after release.
REQ-025 The first frame after release SHALL start with counter = 0 and produce DUTY_MIN-wide pulses.

Configuration
REQ-026 Macro SERVO_BANK_SLEW_EN defined: at each frame update, cur[i] SHALL move toward target[i] by at most STEP, clamped at target (min(cur+STEP,target) or max(cur-STEP,target)).
REQ-027 Macro SERVO_BANK_SLEW_EN undefined: cur[i] SHALL load target[i] directly at the next frame update, and busy[i] SHALL be high for at most the remainder of one frame.

Verification (PERIOD=200, CHANNELS=3, STEP=2, giving DUTY_MIN=10 and DUTY_MAX=20)
REQ-028 Reset, no writes: every servo_out bit is high for 10 of every 200 cycles; frame_tick fires every 200 cycles; busy = 0.
REQ-029 Slew on, write ch0 wr_pos=255: ch0 widths in successive frames are 12,14,16,18,20; busy[0] falls on the update that reaches 20; ch1 and ch2 stay at 10.
REQ-030 Slew off, write ch1 wr_pos=128: next frame width is 15 (10 + 1280>>8); busy[1] clears at that frame start.
REQ-031 Write with wr_ch=3: no target change and busy stays 0; write at counter=199: the current frame is unaffected and the new width applies one frame later.
REQ-032 rst_n pulsed low at counter=5 while servo_out is high: servo_out drops immediately, and after release the cycle from counter=0 is a clean 10-cycle pulse with targets back at DUTY_MIN.
